// File: rtl/rs232c_word_tx_pkg.sv
// Shared definitions for the RS-232C word transmitter: FSM state encoding,
// frame geometry and small width helpers.
package rs232c_word_tx_pkg;

   // Data bits carried by one serial frame.
   localparam int FRAME_DATA_BITS = 8;

   // Serializer states. Encoding is also driven onto o_dbg_state.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_DATA  = 3'd3,
      ST_STOP  = 3'd4
   } tx_state_t;

   // Width of a byte index inside a word; at least one bit so a
   // single-byte word still has a legal index vector.
   function automatic int idx_width(input int word_bytes);
      return (word_bytes > 1) ? $clog2(word_bytes) : 1;
   endfunction

endpackage

// File: rtl/rs232c_word_tx_fifo.sv
// Synchronous word FIFO: registered storage, occupancy count, full/empty.
// A push while full and a pop while empty are ignored.
module sync_word_fifo #(
   parameter int WIDTH = 35,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_count
);

   localparam int          DEPTH      = 1 << AW;
   localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   // Full is judged on the pre-pop count, so a push in the same cycle as a
   // pop from a full FIFO is still dropped.
   assign o_full    = (r_count == FULL_COUNT);
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Storage write; contents need no reset because count guards every read.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   // Pointers wrap naturally at 2**AW; count tracks occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
         else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
      end
   end

endmodule

// File: rtl/rs232c_word_tx.sv
// RS-232C word transmitter. Words (1..WORD_BYTES bytes, low-aligned) are
// queued in a FIFO and sent as 8N1 (or 8N2) frames at WTIME clocks per bit.
// Valid/ready: a word is taken on a rising CLK when in_valid && in_ready;
// in_ready is simply "FIFO not full" and does not depend on in_valid.
module rs232c_word_tx
   import rs232c_word_tx_pkg::*;
#(
   parameter logic [15:0] WTIME      = 16'd6,
   parameter int          WORD_BYTES = 4,
   parameter int          FIFO_AW    = 4,
   parameter int          STOP_BITS  = 1,
   parameter int          MSB_FIRST  = 1
) (
   input  logic                          CLK,
   input  logic                          XRST,
   input  logic [8*WORD_BYTES-1:0]       in_data,
   input  logic [$clog2(WORD_BYTES):0]   in_bytes,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [FIFO_AW:0]              fifo_count,
   output logic [2:0]                    o_dbg_state
);

   localparam int          LW           = $clog2(WORD_BYTES) + 1;
   localparam int          IW           = idx_width(WORD_BYTES);
   localparam int          DW           = 8 * WORD_BYTES;
   localparam int          FW           = DW + LW;
   localparam logic [LW-1:0] FULL_LEN   = LW'(WORD_BYTES);
   localparam logic [15:0] TIMER_RELOAD = WTIME - 16'd1;
   localparam logic [2:0]  LAST_DATA    = 3'(FRAME_DATA_BITS - 1);
   localparam logic [2:0]  LAST_STOP    = 3'(STOP_BITS - 1);

   tx_state_t       r_state;
   tx_state_t       w_next_state;
   logic [15:0]     r_timer;
   logic [2:0]      r_bit_cnt;
   logic [7:0]      r_shift;
   logic [DW-1:0]   r_word;
   logic [IW-1:0]   r_idx;
   logic [LW-1:0]   r_left;

   logic [LW-1:0]   w_in_len;
   logic [FW-1:0]   w_fifo_rdata;
   logic            w_full;
   logic            w_empty;
   logic [DW-1:0]   w_head_data;
   logic [LW-1:0]   w_head_len;
   logic [IW-1:0]   w_first_idx;
   logic [IW-1:0]   w_next_idx;
   logic            w_tick;
   logic            w_pop;
   logic            w_next_byte;
   logic            w_shift;
   logic            w_bit_clr;
   logic            w_bit_inc;

   // Byte idx of a word, selected by shifting so the index width never matters.
   function automatic logic [7:0] pick_byte(input logic [DW-1:0] word,
                                            input logic [IW-1:0] idx);
      logic [DW-1:0] shifted;
      shifted = word >> {idx, 3'b000};
      return shifted[7:0];
   endfunction

   // Length 0 and out-of-range lengths both mean a full word.
   assign w_in_len = ((in_bytes == '0) || (in_bytes > FULL_LEN)) ? FULL_LEN : in_bytes;

   sync_word_fifo #(
      .WIDTH (FW),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk     (CLK),
      .rst_n   (XRST),
      .i_push  (in_valid),
      .i_wdata ({w_in_len, in_data}),
      .i_pop   (w_pop),
      .o_rdata (w_fifo_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (fifo_count)
   );

   assign w_head_data = w_fifo_rdata[DW-1:0];
   assign w_head_len  = w_fifo_rdata[FW-1:DW];
   assign w_first_idx = (MSB_FIRST != 0) ? IW'(w_head_len - 1'b1) : '0;
   assign w_next_idx  = (MSB_FIRST != 0) ? (r_idx - 1'b1) : (r_idx + 1'b1);
   assign w_tick      = (r_timer == 16'd0);

   assign in_ready    = !w_full;
   assign busy        = !((r_state == ST_IDLE) && w_empty);
   assign o_dbg_state = r_state;
   // Line level is decoded from state so reset forces it high at once.
   assign tx = (r_state == ST_START) ? 1'b0 :
               (r_state == ST_DATA)  ? r_shift[0] : 1'b1;

   // State register.
   always_ff @(posedge CLK or negedge XRST) begin
      if (!XRST) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state and datapath strobes. A pop loads the word and its first
   // byte together; from STOP this goes straight to START so consecutive
   // words leave no idle gap on the line.
   always_comb begin
      w_next_state = r_state;
      w_pop        = 1'b0;
      w_next_byte  = 1'b0;
      w_shift      = 1'b0;
      w_bit_clr    = 1'b0;
      w_bit_inc    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_next_state = ST_LOAD;
            end
         end
         ST_LOAD: begin
            w_next_state = ST_START;
         end
         ST_START: begin
            if (w_tick) begin
               w_bit_clr    = 1'b1;
               w_next_state = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_tick) begin
               w_shift = 1'b1;
               if (r_bit_cnt == LAST_DATA) begin
                  w_bit_clr    = 1'b1;
                  w_next_state = ST_STOP;
               end else begin
                  w_bit_inc = 1'b1;
               end
            end
         end
         ST_STOP: begin
            if (w_tick) begin
               if (r_bit_cnt != LAST_STOP) begin
                  w_bit_inc = 1'b1;
               end else if (r_left != '0) begin
                  w_next_byte  = 1'b1;
                  w_next_state = ST_START;
               end else if (!w_empty) begin
                  w_pop        = 1'b1;
                  w_next_state = ST_START;
               end else begin
                  w_next_state = ST_IDLE;
               end
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Bit timer: runs only while a frame is on the line and is held at its
   // reload value otherwise, so LOAD primes it for the start bit.
   always_ff @(posedge CLK or negedge XRST) begin
      if (!XRST) begin
         r_timer <= TIMER_RELOAD;
      end else if ((r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP)) begin
         r_timer <= w_tick ? TIMER_RELOAD : (r_timer - 16'd1);
      end else begin
         r_timer <= TIMER_RELOAD;
      end
   end

   // Word/byte/bit datapath driven by the FSM strobes.
   always_ff @(posedge CLK or negedge XRST) begin
      if (!XRST) begin
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_word    <= '0;
         r_idx     <= '0;
         r_left    <= '0;
      end else begin
         if (w_bit_clr)      r_bit_cnt <= '0;
         else if (w_bit_inc) r_bit_cnt <= r_bit_cnt + 3'd1;

         if (w_pop) begin
            r_word  <= w_head_data;
            r_idx   <= w_first_idx;
            r_left  <= w_head_len - 1'b1;
            r_shift <= pick_byte(w_head_data, w_first_idx);
         end else if (w_next_byte) begin
            r_idx   <= w_next_idx;
            r_left  <= r_left - 1'b1;
            r_shift <= pick_byte(r_word, w_next_idx);
         end else if (w_shift) begin
            r_shift <= {1'b0, r_shift[7:1]};
         end
      end
   end

endmodule

// File: tb/tb_rs232c_word_tx.sv
// Bench for rs232c_word_tx: two builds (MSB-first/1 stop, LSB-first/2 stop)
// share one stimulus stream; each has a line-level reference model that
// expands every word into the expected per-clock tx levels.
module tb_rs232c_word_tx;

   localparam int WT    = 6;
   localparam int DEPTH = 16;

   logic        clk;
   logic        rst_n;
   logic [31:0] in_data;
   logic [2:0]  in_bytes;
   logic        in_valid;

   logic [1:0]  tx_w;
   logic [1:0]  busy_w;
   logic [1:0]  rdy_w;
   logic [4:0]  cnt_w [2];
   logic [2:0]  st_w  [2];

   int n_vec;
   int n_err;

   // clock / reset
   initial clk = 1'b0;
   always #7 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_cfg
      localparam int MF = (g == 0) ? 1 : 0;
      localparam int SB = (g == 0) ? 1 : 2;

      rs232c_word_tx #(
         .WTIME      (16'd6),
         .WORD_BYTES (4),
         .FIFO_AW    (4),
         .STOP_BITS  (SB),
         .MSB_FIRST  (MF)
      ) u_dut (
         .CLK         (clk),
         .XRST        (rst_n),
         .in_data     (in_data),
         .in_bytes    (in_bytes),
         .in_valid    (in_valid),
         .in_ready    (rdy_w[g]),
         .tx          (tx_w[g]),
         .busy        (busy_w[g]),
         .fifo_count  (cnt_w[g]),
         .o_dbg_state (st_w[g])
      );

      // scoreboard: expected line level per clock, plus queued words
      logic [0:0]  exp_q[$];
      logic [31:0] wq_data[$];
      int          wq_len[$];

      // reference model, advanced on every rising edge
      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            exp_q.delete();
            wq_data.delete();
            wq_len.delete();
         end else begin
            logic        acc;
            logic        was_idle;
            logic [31:0] d;
            logic [7:0]  b;
            int          len;
            int          idx;
            acc      = in_valid && (wq_data.size() < DEPTH);
            was_idle = (exp_q.size() == 0);
            if (!was_idle) void'(exp_q.pop_front());
            if ((exp_q.size() == 0) && (wq_data.size() > 0)) begin
               d   = wq_data.pop_front();
               len = wq_len.pop_front();
               if (was_idle) exp_q.push_back(1'b1);
               for (int k = 0; k < len; k++) begin
                  idx = (MF != 0) ? (len - 1 - k) : k;
                  b   = 8'(d >> (8 * idx));
                  repeat (WT) exp_q.push_back(1'b0);
                  for (int j = 0; j < 8; j++) repeat (WT) exp_q.push_back(b[j]);
                  repeat (WT * SB) exp_q.push_back(1'b1);
               end
            end
            if (acc) begin
               wq_data.push_back(in_data);
               wq_len.push_back(((in_bytes == 3'd0) || (in_bytes > 3'd4)) ? 4 : int'(in_bytes));
            end
         end
      end

      // per-cycle comparison on the falling edge
      always @(negedge clk) begin
         check_eq($sformatf("cfg%0d tx", g), 32'(tx_w[g]),
                  (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd1);
         check_eq($sformatf("cfg%0d busy", g), 32'(busy_w[g]),
                  32'((exp_q.size() > 0) || (wq_data.size() > 0)));
         check_eq($sformatf("cfg%0d fifo_count", g), 32'(cnt_w[g]), 32'(wq_data.size()));
         check_eq($sformatf("cfg%0d in_ready", g), 32'(rdy_w[g]), 32'(wq_data.size() < DEPTH));
      end

      // outputs must drop to idle values as soon as reset is asserted
      always @(negedge rst_n) begin
         #1;
         check_eq($sformatf("cfg%0d rst tx", g), 32'(tx_w[g]), 32'd1);
         check_eq($sformatf("cfg%0d rst busy", g), 32'(busy_w[g]), 32'd0);
         check_eq($sformatf("cfg%0d rst count", g), 32'(cnt_w[g]), 32'd0);
         check_eq($sformatf("cfg%0d rst ready", g), 32'(rdy_w[g]), 32'd1);
      end
   end

   // driver tasks (called at posedge+2)
   task automatic push(input logic [31:0] d, input logic [2:0] nb);
      in_data  = d;
      in_bytes = nb;
      in_valid = 1'b1;
      @(posedge clk);
      #2;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      int n;
      n = 0;
      while ((busy_w != 2'b00) && (n < max_cyc)) begin
         @(posedge clk);
         #2;
         n++;
      end
      check_eq("drain_within_bound", 32'(n < max_cyc), 32'd1);
      repeat (3) @(posedge clk);
      #2;
   endtask

   // watchdog
   initial begin
      #(14 * 80000);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // stimulus
   initial begin
      n_vec    = 0;
      n_err    = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_bytes = '0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #2;

      // directed words
      push(32'hffffffff, 3'd0);  wait_idle(2000);
      push(32'h01020304, 3'd4);  wait_idle(2000);
      push(32'h000000ab, 3'd1);  wait_idle(2000);
      push(32'h00000055, 3'd1);  wait_idle(2000);
      push(32'h89abcdef, 3'd7);
      push(32'h12345678, 3'd5);
      push(32'hcafe0102, 3'd2);
      push(32'h00a1b2c3, 3'd3);  wait_idle(4000);

      // back-to-back burst past full
      for (int i = 0; i < 20; i++) push($urandom, 3'($urandom_range(0, 7)));
      wait_idle(8000);

      // reset during the data bits of the second byte
      push(32'hc3a55a3c, 3'd4);
      push($urandom, 3'd4);
      push($urandom, 3'd2);
      repeat (86) @(posedge clk);
      #3 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #2;
      push(32'h0000005a, 3'd1);  wait_idle(2000);

      // random traffic
      for (int i = 0; i < 150; i++) begin
         in_valid = ($urandom_range(0, 3) == 0);
         in_data  = $urandom;
         in_bytes = 3'($urandom_range(0, 7));
         @(posedge clk);
         #2;
      end
      in_valid = 1'b0;
      wait_idle(15000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
